// File: rtl/fwd_pkg.sv
// Shared constants and entry record for the forwarding reservation station.
package fwd_pkg;

  localparam int unsigned FWD_DEPTH  = 8;
  localparam int unsigned FWD_DATA_W = 32;
  localparam int unsigned FWD_TAG_W  = 4;
  localparam int unsigned FWD_NUM_BC = 2;

  // Tag value meaning "no pending source" on entries and "no broadcast" on channels.
  localparam int unsigned TAG_INVALID = 0;

  typedef struct packed {
    logic                  valid;
    logic [FWD_TAG_W-1:0]  target;
    logic [FWD_DATA_W-1:0] val;
    logic [FWD_TAG_W-1:0]  tag;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_age_matrix.sv
// Age matrix for oldest-first selection among requesting slots.
module fwd_age_matrix
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = FWD_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  // r_age[i][j] set means slot i was written before slot j.
  logic [DEPTH-1:0] r_age [DEPTH];

  // Age update: a newly written slot becomes younger than every other slot.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i == j || i_alloc[i]) begin
            r_age[i][j] <= 1'b0;
          end else if (i_alloc[j]) begin
            r_age[i][j] <= 1'b1;
          end else if (i_free[i] || i_free[j]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Grant a requester only if no other requester is older.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && i_req[j] && r_age[j][i]) begin
          o_grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_reserv_station.sv
// Reservation station that waits on a source tag, captures the value from ROB
// broadcasts and forwards resolved entries oldest-first through an output register.
module fwd_reserv_station
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH  = FWD_DEPTH,
  parameter int unsigned DATA_W = FWD_DATA_W,
  parameter int unsigned TAG_W  = FWD_TAG_W,
  parameter int unsigned NUM_BC = FWD_NUM_BC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           in_target,
  input  logic [DATA_W-1:0]          in_val,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [NUM_BC-1:0]          bc_valid,
  input  logic [NUM_BC*TAG_W-1:0]    bc_tag,
  input  logic [NUM_BC*DATA_W-1:0]   bc_val,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_target,
  output logic [DATA_W-1:0]          out_result,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] TagInv = TAG_W'(TAG_INVALID);

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_target [DEPTH];
  logic [DATA_W-1:0] r_val    [DEPTH];
  logic [TAG_W-1:0]  r_tag    [DEPTH];

  logic              r_out_valid;
  logic [TAG_W-1:0]  r_out_target;
  logic [DATA_W-1:0] r_out_result;

  logic [TAG_W-1:0]  w_bc_tag [NUM_BC];
  logic [DATA_W-1:0] w_bc_val [NUM_BC];
  logic [NUM_BC-1:0] w_bc_live;

  logic [DEPTH-1:0]  w_hit;
  logic [DATA_W-1:0] w_hit_val [DEPTH];
  logic              w_in_hit;
  logic [DATA_W-1:0] w_in_hit_val;
  logic [DATA_W-1:0] w_new_val;
  logic [TAG_W-1:0]  w_new_tag;

  logic              w_store;
  logic [DEPTH-1:0]  w_alloc_vec;
  logic [DEPTH-1:0]  w_req;
  logic [DEPTH-1:0]  w_grant;
  logic [DEPTH-1:0]  w_free_vec;
  logic              w_load;
  logic [TAG_W-1:0]  w_sel_target;
  logic [DATA_W-1:0] w_sel_val;
  logic [CntW-1:0]   w_count;

  // Unpack broadcast channels; a zero tag never counts as a broadcast.
  always_comb begin
    for (int c = 0; c < NUM_BC; c++) begin
      w_bc_tag[c]  = bc_tag[c*TAG_W +: TAG_W];
      w_bc_val[c]  = bc_val[c*DATA_W +: DATA_W];
      w_bc_live[c] = bc_valid[c] && (w_bc_tag[c] != TagInv);
    end
  end

  // Tag match for stored and incoming entries; walk channels high to low so the lowest wins.
  always_comb begin
    w_in_hit     = 1'b0;
    w_in_hit_val = '0;
    w_hit        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit_val[k] = '0;
    end
    for (int c = int'(NUM_BC) - 1; c >= 0; c--) begin
      if (w_bc_live[c]) begin
        if (w_bc_tag[c] == in_tag) begin
          w_in_hit     = 1'b1;
          w_in_hit_val = w_bc_val[c];
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (w_bc_tag[c] == r_tag[k]) begin
            w_hit[k]     = 1'b1;
            w_hit_val[k] = w_bc_val[c];
          end
        end
      end
    end
  end

  // Incoming entry contents, resolved on entry when a broadcast carries its tag.
  always_comb begin
    w_new_val = in_val;
    w_new_tag = in_tag;
    if (w_in_hit) begin
      w_new_val = w_in_hit_val;
      w_new_tag = TagInv;
    end
  end

  // Occupancy count and the lowest free slot for allocation.
  always_comb begin
    logic found;
    found       = 1'b0;
    w_count     = '0;
    w_alloc_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CntW'(r_valid[k]);
      if (!r_valid[k] && !found) begin
        found          = 1'b1;
        w_alloc_vec[k] = w_store;
      end
    end
  end

  assign in_ready = rst && (w_count < CntW'(DEPTH)) && !flush;
  // A null target completes the handshake but stores nothing.
  assign w_store  = in_valid && in_ready && (in_target != TagInv);
  assign count    = w_count;

  // Only entries resolved as of the current state may issue.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_req[k] = r_valid[k] && (r_tag[k] == TagInv);
    end
  end

  fwd_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_alloc (w_alloc_vec),
    .i_free  (w_free_vec),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign w_load     = (!r_out_valid || out_ready) && (|w_req);
  assign w_free_vec = w_load ? w_grant : '0;

  // One-hot mux of the granted entry.
  always_comb begin
    w_sel_target = '0;
    w_sel_val    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_grant[k]) begin
        w_sel_target = w_sel_target | r_target[k];
        w_sel_val    = w_sel_val | r_val[k];
      end
    end
  end

  // Entry storage: free issued slot, capture broadcasts, write the new entry.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_target[k] <= '0;
        r_val[k]    <= '0;
        r_tag[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_free_vec[k]) begin
          r_valid[k] <= 1'b0;
        end else if (r_valid[k] && w_hit[k]) begin
          r_val[k] <= w_hit_val[k];
          r_tag[k] <= TagInv;
        end
        if (w_alloc_vec[k]) begin
          r_valid[k]  <= 1'b1;
          r_target[k] <= in_target;
          r_val[k]    <= w_new_val;
          r_tag[k]    <= w_new_tag;
        end
      end
    end
  end

  // Output register: reload when empty or being consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_target <= '0;
      r_out_result <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_target <= w_sel_target;
      r_out_result <= w_sel_val;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_target = r_out_target;
  assign out_result = r_out_result;

endmodule
